// File: rtl/wfg_record_pat.sv
`default_nettype none
// ============================================================================
// Module   : wfg_record_pat
// Brief    : Pattern recorder. Samples input pins at a configured subcycle,
//            masks and queues them, and streams them out over AXI-Stream.
//            Optional macro WFG_RECORD_PAT_SEQ_EN adds an 8-bit sample
//            sequence number in the top byte of tdata.
// Revision : 1.0
// ============================================================================
module wfg_record_pat #(
    parameter int CHANNELS        = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wfg_pat_sync_i,
    input  logic [7:0]                 wfg_pat_subcycle_cnt_i,
    input  logic                       ctrl_en_q_i,
    input  logic [7:0]                 cfg_sample_sub_q_i,
    input  logic [15:0]                cfg_frame_len_q_i,
    input  logic [CHANNELS-1:0]        cfg_mask_q_i,
    input  logic                       overflow_clr_i,
    input  logic [CHANNELS-1:0]        pat_din_i,
    input  logic                       wfg_axis_tready_i,
    output logic                       wfg_axis_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    output logic                       wfg_axis_tlast_o,
    output logic                       overflow_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]                count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic [AXIS_DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

    logic                       w_arm_go, w_se, w_empty, w_full;
    logic                       w_pop, w_push, w_last;
    logic [AXIS_DATA_WIDTH-1:0] w_word;
    logic [AXIS_DATA_WIDTH:0]   w_head;

    // Frames align to a pattern-cycle start: leaving ARM needs a subcycle-0 sync.
    assign w_arm_go = (state_q == ARM) && ctrl_en_q_i && wfg_pat_sync_i
                      && (wfg_pat_subcycle_cnt_i == 8'd0);
    assign w_se     = ((state_q == RUN) || w_arm_go) && wfg_pat_sync_i
                      && (wfg_pat_subcycle_cnt_i == cfg_sample_sub_q_i);

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == DEPTH_C);
    assign w_pop    = !w_empty && wfg_axis_tready_i;
    assign w_push   = w_se && (!w_full || w_pop);
    assign w_last   = (cfg_frame_len_q_i != 16'd0)
                      && (frame_cnt_q == cfg_frame_len_q_i - 16'd1);
    assign w_head   = mem_q[rd_ptr_q];

`ifdef WFG_RECORD_PAT_SEQ_EN
    logic [7:0] seq_q, seq_d;

    always_comb begin
        w_word                        = '0;
        w_word[CHANNELS-1:0]          = pat_din_i & cfg_mask_q_i;
        w_word[AXIS_DATA_WIDTH-1 -: 8] = seq_q;
    end

    // Counts every sample event, dropped ones included, so gaps are visible.
    always_comb begin
        seq_d = seq_q;
        if (state_d == IDLE) begin
            seq_d = 8'd0;
        end else if (w_se) begin
            seq_d = seq_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            seq_q <= 8'd0;
        end else begin
            seq_q <= seq_d;
        end
    end
`else
    always_comb begin
        w_word               = '0;
        w_word[CHANNELS-1:0] = pat_din_i & cfg_mask_q_i;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl_en_q_i) state_d = ARM;
            ARM:     if (w_arm_go) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!ctrl_en_q_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d == IDLE) begin
            frame_cnt_d = 16'd0;
        end else if (w_push) begin
            frame_cnt_d = w_last ? 16'd0 : frame_cnt_q + 16'd1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // A new overflow takes priority over a clear arriving in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (w_se && !w_push) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            frame_cnt_q <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {w_word, w_last};
        end
    end

    assign wfg_axis_tvalid_o = !w_empty;
    assign wfg_axis_tdata_o  = w_empty ? '0 : w_head[AXIS_DATA_WIDTH:1];
    assign wfg_axis_tlast_o  = !w_empty && w_head[0];
    assign overflow_o        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_wfg_record_pat.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfg_record_pat
// Brief    : Directed self-checking bench for wfg_record_pat.
// Revision : 1.0
// ============================================================================
module tb_wfg_record_pat;

`ifdef WFG_RECORD_PAT_SEQ_EN
    localparam int CH = 24;
`else
    localparam int CH = 32;
`endif
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync = 1'b0;
    logic [7:0]    subcnt = 8'd0;
    logic          en = 1'b0;
    logic [7:0]    cfg_sub = 8'd3;
    logic [15:0]   cfg_len = 16'd4;
    logic [CH-1:0] cfg_mask = '1;
    logic          clr = 1'b0;
    logic [CH-1:0] din = '0;
    logic          tready = 1'b1;
    logic          tvalid, tlast, ovf;
    logic [DW-1:0] tdata;

    int checks = 0;
    int errors = 0;

    wfg_record_pat #(.CHANNELS(CH), .AXIS_DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .wb_clk_i               (clk),
        .wb_rst_i               (rst),
        .wfg_pat_sync_i         (sync),
        .wfg_pat_subcycle_cnt_i (subcnt),
        .ctrl_en_q_i            (en),
        .cfg_sample_sub_q_i     (cfg_sub),
        .cfg_frame_len_q_i      (cfg_len),
        .cfg_mask_q_i           (cfg_mask),
        .overflow_clr_i         (clr),
        .pat_din_i              (din),
        .wfg_axis_tready_i      (tready),
        .wfg_axis_tvalid_o      (tvalid),
        .wfg_axis_tdata_o       (tdata),
        .wfg_axis_tlast_o       (tlast),
        .overflow_o             (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_word(input logic [31:0] d, input logic [7:0] s);
`ifdef WFG_RECORD_PAT_SEQ_EN
        return {s, d[23:0]};
`else
        if (s == 8'hFF) return 32'hFFFF_FFFF; // unreachable seq value keeps s used
        return d;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] sub, input logic [31:0] d);
        sync   = 1'b1;
        subcnt = sub;
        din    = d[CH-1:0];
        cyc();
        sync   = 1'b0;
        subcnt = 8'd0;
    endtask

    task automatic arm_run();
        en = 1'b0;
        cyc();
        en = 1'b1;
        cyc();
        pulse(8'd0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({tvalid, tlast, ovf, tdata} !== 35'd0) begin
            errors++;
            $display("FAIL reset: got v%b l%b o%b d%h required all zero", tvalid, tlast, ovf, tdata);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_arm();
        en = 1'b1;
        cyc();
        pulse(8'd5, 32'h55);
        pulse(8'd3, 32'h66);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL arm_hold: tvalid got %b required 0", tvalid);
        end
        pulse(8'd0, 32'h0);
        pulse(8'd1, 32'h77);
        pulse(8'd7, 32'h78);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL wrong_subcycle: tvalid got %b required 0", tvalid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 32'h11 * (i + 1);
            pulse(8'd3, v);
            checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, (i == 3), exp_word(v, 8'(i))}) begin
                errors++;
                $display("FAIL basic_beat%0d: got v%b l%b d%h required v1 l%b d%h",
                         i, tvalid, tlast, tdata, (i == 3), exp_word(v, 8'(i)));
            end
            cyc();
            checks++;
            if (tvalid !== 1'b0) begin
                errors++;
                $display("FAIL basic_pop%0d: tvalid got %b required 0", i, tvalid);
            end
        end
    endtask

    task automatic test_mask();
        cfg_mask = CH'(32'h0000_00F0);
        pulse(8'd3, 32'hABCD_1234);
        checks++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, exp_word(32'h30, 8'd4)}) begin
            errors++;
            $display("FAIL mask: got v%b l%b d%h required v1 l0 d%h",
                     tvalid, tlast, tdata, exp_word(32'h30, 8'd4));
        end
        cyc();
        cfg_mask = '1;
    endtask

    task automatic test_overflow();
        arm_run();
        tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            pulse(8'd3, 32'(i));
            checks++;
            if ({tvalid, tlast, tdata, ovf} !== {1'b1, 1'b0, exp_word(32'h1, 8'd0), (i >= 5)}) begin
                errors++;
                $display("FAIL ovf_hold%0d: got v%b l%b d%h o%b required v1 l0 d%h o%b",
                         i, tvalid, tlast, tdata, ovf, exp_word(32'h1, 8'd0), (i >= 5));
            end
        end
        tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, (k == 3), exp_word(32'(k + 1), 8'(k))}) begin
                errors++;
                $display("FAIL ovf_drain%0d: got v%b l%b d%h required v1 l%b d%h",
                         k, tvalid, tlast, tdata, (k == 3), exp_word(32'(k + 1), 8'(k)));
            end
            cyc();
        end
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: tvalid got %b required 0", tvalid);
        end
        pulse(8'd3, 32'h7);
        checks++;
        if ({tvalid, tlast, tdata, ovf} !== {1'b1, 1'b0, exp_word(32'h7, 8'd6), 1'b1}) begin
            errors++;
            $display("FAIL ovf_next: got v%b l%b d%h o%b required v1 l0 d%h o1",
                     tvalid, tlast, tdata, ovf, exp_word(32'h7, 8'd6));
        end
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", ovf);
        end
    endtask

    task automatic test_pushpop();
        arm_run();
        tready = 1'b0;
        for (int i = 1; i <= 4; i++) pulse(8'd3, 32'(i));
        tready = 1'b1;
        pulse(8'd3, 32'h5);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_ovf: got %b required 0", ovf);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, (k == 2), exp_word(32'(k + 2), 8'(k + 1))}) begin
                errors++;
                $display("FAIL pushpop_beat%0d: got v%b l%b d%h required v1 l%b d%h",
                         k, tvalid, tlast, tdata, (k == 2), exp_word(32'(k + 2), 8'(k + 1)));
            end
            cyc();
        end
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_empty: tvalid got %b required 0", tvalid);
        end
    endtask

    task automatic test_disable();
        arm_run();
        tready = 1'b0;
        pulse(8'd3, 32'hA);
        pulse(8'd3, 32'hB);
        en = 1'b0;
        cyc();
        tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, exp_word(32'(10 + k), 8'(k))}) begin
                errors++;
                $display("FAIL dis_drain%0d: got v%b l%b d%h required v1 l0 d%h",
                         k, tvalid, tlast, tdata, exp_word(32'(10 + k), 8'(k)));
            end
            cyc();
        end
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL dis_empty: tvalid got %b required 0", tvalid);
        end
        en = 1'b1;
        cyc();
        pulse(8'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            pulse(8'd3, 32'(12 + i));
            checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, (i == 3), exp_word(32'(12 + i), 8'(i))}) begin
                errors++;
                $display("FAIL reen_beat%0d: got v%b l%b d%h required v1 l%b d%h",
                         i, tvalid, tlast, tdata, (i == 3), exp_word(32'(12 + i), 8'(i)));
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        tready = 1'b0;
        pulse(8'd3, 32'h1);
        pulse(8'd3, 32'h2);
        rst = 1'b1;
        cyc();
        checks++;
        if ({tvalid, tlast, ovf, tdata} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid: got v%b l%b o%b d%h required all zero", tvalid, tlast, ovf, tdata);
        end
        rst = 1'b0;
        en  = 1'b0;
        cyc();
    endtask

    initial begin
        #1;
        test_reset();
        test_arm();
        test_basic();
        test_mask();
        test_overflow();
        test_pushpop();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wfg_record_pat.md
Name: wfg_record_pat

Overview:
- Pattern recorder; the receive-side counterpart of the pattern driver.
- Samples CHANNELS input pins once per pattern cycle, at a configured subcycle of the core sync interface.
- Masks each sample and queues it in a small FIFO.
- Emits samples as an AXI-Stream master, with tlast marking configurable frame boundaries.

Parameters:
- CHANNELS, 32, number of sampled input pins; must be <= AXIS_DATA_WIDTH.
- AXIS_DATA_WIDTH, 32, AXI-Stream tdata width.
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, >= 2.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wfg_pat_sync_i  in  1  pattern sync pulse from core.
- wfg_pat_subcycle_cnt_i  in  8  subcycle count from core.
- ctrl_en_q_i  in  1  recorder enable.
- cfg_sample_sub_q_i  in  8  subcycle at which pins are sampled.
- cfg_frame_len_q_i  in  16  samples per frame; 0 = never assert tlast.
- cfg_mask_q_i  in  CHANNELS  per-channel capture enable; masked bits read 0.
- overflow_clr_i  in  1  single-cycle pulse; clears overflow_o.
- pat_din_i  in  CHANNELS  input pins, already synchronised to wb_clk_i.
- wfg_axis_tready_i  in  1  downstream ready.
- wfg_axis_tvalid_o  out  1  data valid.
- wfg_axis_tdata_o  out  AXIS_DATA_WIDTH  sample, zero-extended.
- wfg_axis_tlast_o  out  1  last sample of frame.
- overflow_o  out  1  sticky; a sample was dropped because the FIFO was full.

Behaviour:
- Reset:
  - FSM = IDLE; FIFO empty; frame counter = 0.
  - tvalid_o = 0, tdata_o = 0, tlast_o = 0, overflow_o = 0.
- Sample event (SE): state RUN && wfg_pat_sync_i && wfg_pat_subcycle_cnt_i == cfg_sample_sub_q_i.
- FSM states:
  - IDLE: ctrl_en_q_i = 1 -> ARM.
  - ARM: waits for wfg_pat_sync_i with subcycle_cnt == 0, which aligns frames to a pattern-cycle start. That same cycle -> RUN; an SE is also evaluated in that cycle.
  - RUN: takes samples.
  - ctrl_en_q_i = 0 in any state -> IDLE next cycle. Frame counter resets to 0; FIFO is NOT flushed and keeps draining.
- Data and tlast:
  - On SE, entry = {zero-extend(pat_din_i & cfg_mask_q_i), last}.
  - last = (cfg_frame_len_q_i != 0) && (frame_cnt == cfg_frame_len_q_i - 1).
  - Frame counter advances only on an accepted push; it wraps to 0 after the last sample.
- Latency:
  - Pins captured at the SE edge; entry written at the same edge.
  - tvalid_o rises the next cycle if the FIFO was empty (1-cycle latency).
- Output: tvalid_o = !empty; tdata_o/tlast_o = head entry. Head is stable while tvalid_o && !tready_i (AXIS rule: no retraction, no change).
- Pop: tvalid_o && wfg_axis_tready_i.
- Push and pop in the same cycle: both occur, count unchanged. Allowed when full: pop frees the slot and the push is accepted.
- FIFO full, SE, no pop:
  - Sample dropped; frame counter not advanced.
  - overflow_o set next cycle.
- overflow_o:
  - Stays set until overflow_clr_i or reset.
  - Clear and a new overflow in the same cycle: set wins.
- cfg_* inputs may change anytime. They take effect on the next SE and are not retroactive to queued entries.
- A frame truncated by disable gets no tlast.
- Reset asserted mid-operation: FIFO discarded immediately; outputs at reset values on the next cycle.

Optional Feature:
- Macro WFG_RECORD_PAT_SEQ_EN.
- Defined:
  - tdata_o[AXIS_DATA_WIDTH-1 -: 8] carries an 8-bit sample sequence number; requires CHANNELS <= AXIS_DATA_WIDTH-8.
  - Increments on every SE, including dropped ones, so the host can detect gaps. Wraps 255 -> 0.
  - Resets to 0 on reset and on entering IDLE.
- Undefined:
  - No sequence counter.
  - Upper bits above CHANNELS are zero.

Test Plan:
- Reset, then enable with cfg_sample_sub = 3, frame_len = 4, mask = 0xFFFF_FFFF, tready = 1. Drive pat_din = 0x11, 0x22, 0x33, 0x44 at successive SEs. -> 4 beats with tdata 0x11..0x44; tlast only on 0x44; each tvalid 1 cycle after its SE.
- Sync pulses arrive with subcycle_cnt != 3 -> no beats. Enable raised mid-cycle with a first sync at subcycle 5 -> ARM holds; no sample until after a subcycle-0 sync.
- mask = 0x0000_00F0, pat_din = 0xABCD_1234 -> tdata = 0x0000_0030.
- tready = 0, 6 SEs with FIFO_DEPTH = 4 -> 4 beats held with stable tdata; overflow_o = 1 after SE 5. Then tready = 1 -> exactly 4 beats, tlast on the 4th. overflow_clr_i pulse -> overflow_o = 0.
- FIFO full with tready = 1 at an SE cycle -> simultaneous pop and push; no overflow.
- Disable after 2 of 4 samples while 2 are queued -> both drain with tlast = 0. Re-enable -> the new frame's 4th sample carries tlast.
- With WFG_RECORD_PAT_SEQ_EN defined: repeat the overflow case -> seq fields 0, 1, 2, 3, then after draining the next accepted sample shows 6.
